// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: bus timing constants, filter length, host-transmit
// FSM state encoding and the frame parity helper. Used by ps2_tx, its line
// filter and kb_interface.
package ps2_pkg;

   // 100 us of clock inhibit before a request-to-send at 65 MHz
   localparam int unsigned PS2_INHIBIT_CYCLES = 6500;
   // 15 ms maximum gap between device clock falling edges at 65 MHz
   localparam int unsigned PS2_TIMEOUT_CYCLES = 975000;
   // consecutive low samples needed to accept a falling edge
   localparam int unsigned PS2_FILTER_LEN     = 8;
   localparam int unsigned PS2_FILTER_CNT_W   = $clog2(PS2_FILTER_LEN);
   // holds device clock edge numbers 0..10
   localparam int unsigned PS2_EDGE_CNT_W     = 4;

   typedef enum logic [2:0] {
      PS2_IDLE    = 3'd0,
      PS2_INHIBIT = 3'd1,
      PS2_REQUEST = 3'd2,
      PS2_SHIFT   = 3'd3,
      PS2_ACK     = 3'd4,
      PS2_RELEASE = 3'd5
   } ps2_tx_state_e;

   // odd parity: the parity bit makes the total count of ones odd
   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~(^b);
   endfunction

endpackage

// File: rtl/ps2_tx_line_filter.sv
// ps2_line_filter: two-flop synchronizer plus a run-length glitch filter for
// one raw PS/2 line.
//   clk, reset  : system clock, synchronous active-high reset
//   line_in     : raw asynchronous line level
//   level       : filtered line level (flips after PS2_FILTER_LEN agreeing samples)
//   fall_tick   : one-cycle pulse when the filtered level goes high -> low
module ps2_line_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic fall_tick
);

   localparam int unsigned CNT_W = PS2_FILTER_CNT_W;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             fall_q,  fall_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // count consecutive synchronized samples that disagree with the filtered level
   always_comb begin
      sync1_d = line_in;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(PS2_FILTER_LEN - 1)) begin
            level_d = sync2_q;
            fall_d  = level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // idle bus is high, so the line is assumed released out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign level     = level_q;
   assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send,
// shift on device clock, ACK check, bus release).
//   clk, reset           : system clock, synchronous active-high reset
//   tx_start, tx_data    : send request (honoured only when idle) and command byte
//   ps2_clk_in/_data_in  : raw bus line levels
//   ps2_clk_oe/_data_oe  : 1 pulls the corresponding open-drain line low
//   tx_busy              : transfer in progress
//   tx_done, tx_error    : one-cycle completion / failure pulses
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned EDGE_W = PS2_EDGE_CNT_W;

   logic clk_level, clk_fall;
   logic data_level, data_fall_unused;

   ps2_line_filter u_clk_filter (
      .clk       (clk),
      .reset     (reset),
      .line_in   (ps2_clk_in),
      .level     (clk_level),
      .fall_tick (clk_fall)
   );

   ps2_line_filter u_data_filter (
      .clk       (clk),
      .reset     (reset),
      .line_in   (ps2_data_in),
      .level     (data_level),
      .fall_tick (data_fall_unused)
   );

   ps2_tx_state_e     state_q,    state_d;
   logic [INH_W-1:0]  inh_cnt_q,  inh_cnt_d;
   logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
   logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [7:0]        byte_q,     byte_d;
   logic              parity_q,   parity_d;
   logic              clk_oe_q,   clk_oe_d;
   logic              data_oe_q,  data_oe_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              error_q,    error_d;

   logic timed_state;
   logic timeout_hit;

   // the watchdog only runs while waiting on device clock edges
   assign timed_state = (state_q == PS2_SHIFT) || (state_q == PS2_ACK) ||
                        (state_q == PS2_RELEASE);
   assign timeout_hit = timed_state && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      inh_cnt_d  = inh_cnt_q;
      edge_cnt_d = edge_cnt_q;
      byte_d     = byte_q;
      parity_d   = parity_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      to_cnt_d   = '0;

      if (timed_state && !clk_fall) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      case (state_q)
         PS2_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_start) begin
               byte_d    = tx_data;
               parity_d  = ps2_odd_parity(tx_data);
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
               inh_cnt_d = '0;
               state_d   = PS2_INHIBIT;
            end
         end

         PS2_INHIBIT: begin
            if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
               inh_cnt_d = '0;
               data_oe_d = 1'b1;
               state_d   = PS2_REQUEST;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end

         // start bit is already on the wire; hand the clock to the device
         PS2_REQUEST: begin
            clk_oe_d   = 1'b0;
            edge_cnt_d = '0;
            state_d    = PS2_SHIFT;
         end

         // edge n (1-based) = edge_cnt_q + 1: data bits, then parity, then stop
         PS2_SHIFT: begin
            if (timeout_hit) begin
               error_d   = 1'b1;
               busy_d    = 1'b0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               state_d   = PS2_IDLE;
            end else if (clk_fall) begin
               edge_cnt_d = edge_cnt_q + EDGE_W'(1);
               if (edge_cnt_q < EDGE_W'(8)) begin
                  data_oe_d = ~byte_q[edge_cnt_q[2:0]];
               end else if (edge_cnt_q == EDGE_W'(8)) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = PS2_ACK;
               end
            end
         end

         PS2_ACK: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (timeout_hit) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = PS2_IDLE;
            end else if (clk_fall) begin
               if (!data_level) begin
                  state_d = PS2_RELEASE;
               end else begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = PS2_IDLE;
               end
            end
         end

         PS2_RELEASE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (timeout_hit) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = PS2_IDLE;
            end else if (clk_level && data_level) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = PS2_IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = PS2_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PS2_IDLE;
         inh_cnt_q  <= '0;
         to_cnt_q   <= '0;
         edge_cnt_q <= '0;
         byte_q     <= '0;
         parity_q   <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         inh_cnt_q  <= inh_cnt_d;
         to_cnt_q   <= to_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         byte_q     <= byte_d;
         parity_q   <= parity_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: a PS/2 device model on an open-drain bus, directed
// transfers with hand-computed frames, and pulse monitoring.
module tb_ps2_tx;

   localparam int unsigned INH  = 6500;
   localparam int unsigned TO   = 300;
   localparam int unsigned HALF = 20;
   // raw fall -> FSM reaction: 2 sync flops + 8 filter samples + 1 FSM register
   localparam int unsigned LAT  = 11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       bus_clk, bus_data;
   logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

   assign bus_clk  = dev_clk  & ~ps2_clk_oe;
   assign bus_data = dev_data & ~ps2_data_oe;

   ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .ps2_clk_in  (bus_clk),
      .ps2_data_in (bus_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, err_cyc = 0;
   int inh_cnt = 0, req_cnt = 0;
   logic err_clk_oe = 1'b0, err_data_oe = 1'b0;
   logic busy_after_done = 1'b1;
   logic prev_done = 1'b0, prev_err = 1'b0;
   int fall_cyc [1:11];
   int fall_num = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // pulse bookkeeping, sampled mid-cycle
   always @(negedge clk) begin
      if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_cnt++;
      if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) req_cnt++;
      if (prev_done) busy_after_done = tx_busy;
      if (tx_done === 1'b1) done_cnt++;
      if (tx_error === 1'b1) begin
         err_cnt++;
         err_cyc     = cyc;
         err_clk_oe  = ps2_clk_oe;
         err_data_oe = ps2_data_oe;
      end
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
         checks++;
         if ((tx_done && tx_error) || (tx_done && prev_done) || (tx_error && prev_err)) begin
            failures++;
            $display("FAIL pulse_shape cyc=%0d done=%b error=%b prev_done=%b prev_error=%b, required single non-overlapping pulses",
                     cyc, tx_done, tx_error, prev_done, prev_err);
         end
      end
      prev_done = tx_done;
      prev_err  = tx_error;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "time limit reached");
   end

   // device side of a host-to-device frame; bits[0]=start .. bits[10]=stop
   task automatic device_xfer(input int stop_after, input bit give_ack,
                              output logic [10:0] bits, output bit got_req);
      int waited;
      bits    = '0;
      got_req = 1'b0;
      waited  = 0;
      while (!(bus_clk === 1'b1 && bus_data === 1'b0) && waited < int'(INH) + 400) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!(bus_clk === 1'b1 && bus_data === 1'b0)) return;
      got_req = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 bits[0] = bus_data;
      for (int e = 1; e <= 11; e++) begin
         if (e > stop_after) break;
         repeat (HALF) @(posedge clk);
         #1 dev_clk = 1'b0;
         fall_cyc[e] = cyc;
         fall_num    = e;
         repeat (HALF) @(posedge clk);
         #1;
         if (e <= 10) bits[e] = bus_data;
         dev_clk = 1'b1;
         if (e == 10 && give_ack) dev_data = 1'b0;
         if (e == 11) dev_data = 1'b1;
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(posedge clk); #1;
      tx_data  = d;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   task automatic wait_outcome(input int d0, input int e0, input int budget, output bit timed_out);
      int n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      timed_out = (done_cnt == d0 && err_cnt == e0);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset;
      @(posedge clk);
      @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
      checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done); end
      checks++; if (tx_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", tx_error); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
   endtask

   task automatic test_ed_frame;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt; inh_cnt = 0; req_cnt = 0;
      fork
         device_xfer(11, 1'b1, bits, got);
         start_tx(8'hED);
      join
      wait_outcome(d0, e0, 200, tmo);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL ed_request got=%b exp=1", got); end
      checks++; if (inh_cnt != int'(INH)) begin failures++; $display("FAIL ed_inhibit_len got=%0d exp=%0d", inh_cnt, INH); end
      checks++; if (req_cnt != 1) begin failures++; $display("FAIL ed_request_len got=%0d exp=1", req_cnt); end
      checks++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin failures++; $display("FAIL ed_bits got=%b exp=%b", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
      checks++; if (tmo || done_cnt - d0 != 1) begin failures++; $display("FAIL ed_done_count got=%0d exp=1", done_cnt - d0); end
      checks++; if (err_cnt != e0) begin failures++; $display("FAIL ed_no_error got=%0d exp=0", err_cnt - e0); end
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL ed_released got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_f4_frame;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fork
         device_xfer(11, 1'b1, bits, got);
         start_tx(8'hF4);
      join
      wait_outcome(d0, e0, 200, tmo);
      checks++; if (bits[9] !== 1'b0) begin failures++; $display("FAIL f4_parity got=%b exp=0", bits[9]); end
      checks++; if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin failures++; $display("FAIL f4_bits got=%b exp=%b", bits, {1'b1, 1'b0, 8'hF4, 1'b0}); end
      checks++; if (tmo || done_cnt - d0 != 1) begin failures++; $display("FAIL f4_done_count got=%0d exp=1", done_cnt - d0); end
      checks++; if (busy_after_done !== 1'b0) begin failures++; $display("FAIL f4_busy_after_done got=%b exp=0", busy_after_done); end
      checks++; if (err_cnt != e0) begin failures++; $display("FAIL f4_no_error got=%0d exp=0", err_cnt - e0); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_nack;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fork
         device_xfer(11, 1'b0, bits, got);
         start_tx(8'h3C);
      join
      wait_outcome(d0, e0, 200, tmo);
      checks++; if (tmo || err_cnt - e0 != 1) begin failures++; $display("FAIL nack_error_count got=%0d exp=1", err_cnt - e0); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL nack_no_done got=%0d exp=0", done_cnt - d0); end
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL nack_released got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL nack_busy got=%b exp=0", tx_busy); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_timeout;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fork
         device_xfer(4, 1'b1, bits, got);
         start_tx(8'hA5);
      join
      wait_outcome(d0, e0, int'(TO) + 200, tmo);
      checks++; if (bits[4:0] !== 5'b01010) begin failures++; $display("FAIL to_bits got=%b exp=01010", bits[4:0]); end
      checks++; if (tmo || err_cnt - e0 != 1) begin failures++; $display("FAIL to_error_count got=%0d exp=1", err_cnt - e0); end
      checks++; if (err_cyc - fall_cyc[4] != int'(TO + LAT)) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", err_cyc - fall_cyc[4], TO + LAT); end
      checks++; if ({err_clk_oe, err_data_oe} !== 2'b00) begin failures++; $display("FAIL to_released got=%b exp=00", {err_clk_oe, err_data_oe}); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL to_no_done got=%0d exp=0", done_cnt - d0); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0, n;
      d0 = done_cnt; e0 = err_cnt; fall_num = 0;
      fork
         device_xfer(6, 1'b1, bits, got);
         begin
            start_tx(8'h00);
            n = 0;
            while (fall_num < 6 && n < int'(INH) + 1000) begin @(posedge clk); #1; n++; end
            if (fall_num >= 6) begin
               while (cyc < fall_cyc[6] + 12) begin @(posedge clk); #1; end
            end
            checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rst_pre_data_oe got=%b exp=1", ps2_data_oe); end
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL rst_released got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
            checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
            @(posedge clk); #1 reset = 1'b0;
         end
      join
      repeat (100) @(posedge clk);
      checks++; if (done_cnt != d0 || err_cnt != e0) begin failures++; $display("FAIL rst_no_pulse done=%0d error=%0d exp=0,0", done_cnt - d0, err_cnt - e0); end
      fork
         device_xfer(11, 1'b1, bits, got);
         start_tx(8'hFF);
      join
      wait_outcome(d0, e0, 200, tmo);
      checks++; if (bits !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin failures++; $display("FAIL rst_ff_bits got=%b exp=%b", bits, {1'b1, 1'b1, 8'hFF, 1'b0}); end
      checks++; if (tmo || done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL rst_ff_done done=%0d error=%0d exp=1,0", done_cnt - d0, err_cnt - e0); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_back_to_back;
      logic [10:0] bits;
      bit got, tmo;
      int d0, e0, n;
      logic busy_at_pulse;
      d0 = done_cnt; e0 = err_cnt; fall_num = 0; busy_at_pulse = 1'b0;
      fork
         device_xfer(11, 1'b1, bits, got);
         begin
            start_tx(8'hED);
            n = 0;
            while (fall_num < 3 && n < int'(INH) + 1000) begin @(posedge clk); #1; n++; end
            busy_at_pulse = tx_busy;
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(posedge clk); #1;
            tx_start = 1'b0;
         end
      join
      wait_outcome(d0, e0, 200, tmo);
      checks++; if (busy_at_pulse !== 1'b1) begin failures++; $display("FAIL b2b_busy_at_pulse got=%b exp=1", busy_at_pulse); end
      checks++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin failures++; $display("FAIL b2b_bits got=%b exp=%b", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
      checks++; if (tmo || done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL b2b_done done=%0d error=%0d exp=1,0", done_cnt - d0, err_cnt - e0); end
      repeat (200) @(posedge clk);
      @(negedge clk);
      checks++; if ({tx_busy, ps2_clk_oe} !== 2'b00) begin failures++; $display("FAIL b2b_no_restart busy,clk_oe got=%b exp=00", {tx_busy, ps2_clk_oe}); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL b2b_single_done got=%0d exp=1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_ed_frame();
      test_f4_frame();
      test_nack();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
